// File: rtl/mult_div_unit_if.sv
// Handshake and HI/LO bus between the pipeline and the multiply/divide unit.
// The pipeline side is the master; the unit itself is the slave.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wd;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wd,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wd,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes; the sign is restored in a single FIX cycle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   mult_div_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

   state_t             state_q;
   logic [5:0]         cnt_q;
   logic               is_div_q;
   logic               neg_res_q;
   logic               neg_rem_q;
   logic               div_zero_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [2*WIDTH-1:0] acc_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               signed_op;
   logic               is_div;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   always_comb begin
      signed_op = ~bus.op[0];
      is_div    = bus.op[1];
      a_neg     = signed_op & bus.a[WIDTH-1];
      b_neg     = signed_op & bus.b[WIDTH-1];
      a_mag     = a_neg ? -bus.a : bus.a;
      b_mag     = b_neg ? -bus.b : bus.b;
   end

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   end

   // Divide: acc = {remainder, dividend/quotient}, shifted left; quotient bits enter at LSB.
   // The remainder stays below the divisor, so WIDTH bits hold it after each step.
   logic [WIDTH:0]     div_part;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      div_part = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge   = div_part >= {1'b0, opnd_q};
      div_rem  = div_ge ? (div_part[WIDTH-1:0] - opnd_q) : div_part[WIDTH-1:0];
      div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
   end

   logic [2*WIDTH-1:0] prod_res;
   logic [WIDTH-1:0]   quo_mag;
   logic [WIDTH-1:0]   rem_mag;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   // A zero divisor leaves the dividend magnitude as remainder, so HI comes back as a.
   always_comb begin
      prod_res = neg_res_q ? -acc_q : acc_q;
      quo_mag  = acc_q[WIDTH-1:0];
      rem_mag  = acc_q[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         res_hi = neg_rem_q ? -rem_mag : rem_mag;
         res_lo = div_zero_q ? '1 : (neg_res_q ? -quo_mag : quo_mag);
      end else begin
         res_hi = prod_res[2*WIDTH-1:WIDTH];
         res_lo = prod_res[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         opnd_q     <= '0;
         acc_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.hi_we) hi_q <= bus.wd;
               if (bus.lo_we) lo_q <= bus.wd;
               if (bus.start) begin
                  state_q    <= CALC;
                  busy_q     <= 1'b1;
                  cnt_q      <= '0;
                  is_div_q   <= is_div;
                  neg_res_q  <= a_neg ^ b_neg;
                  neg_rem_q  <= a_neg;
                  div_zero_q <= is_div & (bus.b == '0);
                  opnd_q     <= is_div ? b_mag : a_mag;
                  acc_q      <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
               end
            end
            CALC: begin
               acc_q <= is_div_q ? div_next : mul_next;
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == LAST_ITER) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= res_hi;
               lo_q    <= res_lo;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against a plain-arithmetic model.
module tb_mult_div_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   quiet_bad;

   mult_div_unit_if #(.WIDTH(W)) bus ();

   mult_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns {HI, LO} for the requested operation.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
      longint sx;
      longint sy;
      int     qi;
      int     ri;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'd0: return 64'(sx * sy);
         2'd1: return {32'd0, x} * {32'd0, y};
         default: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            if (o == 2'd3) return {x % y, x / y};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            qi = $signed(x) / $signed(y);
            ri = $signed(x) % $signed(y);
            return {32'(ri), 32'(qi)};
         end
      endcase
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Entered and left at 1 time unit after a rising edge.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit poke, input bit mt, input logic [31:0] mt_val);
      logic [63:0] exp;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      int          cycles;
      bit          moved;
      exp       = model(o, x, y);
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      bus.start = 1'b1;
      if (mt) begin
         bus.hi_we = 1'b1;
         bus.lo_we = 1'b1;
         bus.wd    = mt_val;
         pre_hi    = mt_val;
         pre_lo    = mt_val;
      end else begin
         pre_hi = bus.hi;
         pre_lo = bus.lo;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.a     = 32'($urandom);
      bus.b     = 32'($urandom);
      bus.op    = 2'($urandom);
      cycles    = 0;
      moved     = 1'b0;
      while (bus.busy && cycles < 100) begin
         cycles++;
         if (bus.hi !== pre_hi || bus.lo !== pre_lo || bus.done !== 1'b0) moved = 1'b1;
         if (poke && cycles == 5) begin
            bus.start = 1'b1;
            bus.hi_we = 1'b1;
            bus.lo_we = 1'b1;
            bus.wd    = 32'($urandom);
         end else begin
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
            bus.lo_we = 1'b0;
         end
         @(posedge clk); #1;
      end
      check("busy_cycles", 64'(cycles), 64'(W + 1));
      check("hold_while_busy", 64'(moved), 64'd0);
      check("done", 64'(bus.done), 64'd1);
      check("hi", 64'(bus.hi), 64'(exp[63:32]));
      check("lo", 64'(bus.lo), 64'(exp[31:0]));
      $display("op=%0d a=%h b=%h -> hi=%h lo=%h (model hi=%h lo=%h) busy_cycles=%0d",
               o, x, y, bus.hi, bus.lo, exp[63:32], exp[31:0], cycles);
      @(posedge clk); #1;
      check("done_single", 64'(bus.done), 64'd0);
      check("idle_after", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = 2'd0;
      bus.a     = '0;
      bus.b     = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wd    = '0;
      #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;

      bus.lo_we = 1'b1;
      bus.wd    = 32'h1234_5678;
      @(posedge clk); #1;
      bus.lo_we = 1'b0;
      check("mtlo", 64'(bus.lo), 64'h1234_5678);
      $display("MTLO wd=12345678 -> lo=%h", bus.lo);
      bus.hi_we = 1'b1;
      bus.wd    = 32'hCAFE_F00D;
      @(posedge clk); #1;
      bus.hi_we = 1'b0;
      check("mthi", 64'(bus.hi), 64'hCAFE_F00D);
      check("mthi_lo_kept", 64'(bus.lo), 64'h1234_5678);
      $display("MTHI wd=cafef00d -> hi=%h", bus.hi);

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
      run_op(2'd0, 32'hFFFF_FFFD, 32'd7,         1'b0, 1'b0, 32'h0);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0, 32'h0);
      run_op(2'd3, 32'd100,       32'd0,         1'b0, 1'b0, 32'h0);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
      run_op(2'd2, 32'hFFFF_FFF0, 32'd0,         1'b0, 1'b0, 32'h0);
      run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0);
      run_op(2'd3, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h0);
      run_op(2'd1, 32'd3,         32'd5,         1'b0, 1'b1, 32'hA5A5_A5A5);

      // Abort an operation ten cycles into CALC.
      bus.op    = 2'd2;
      bus.a     = 32'h7FFF_1234;
      bus.b     = 32'd3;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("busy_before_abort", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_hi", 64'(bus.hi), 64'd0);
      check("abort_lo", 64'(bus.lo), 64'd0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      quiet_bad = 1'b0;
      repeat (40) begin
         if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
            quiet_bad = 1'b1;
         @(posedge clk); #1;
      end
      check("abort_no_result", 64'(quiet_bad), 64'd0);
      $display("reset at CALC cycle 10 -> busy=%0d done=%0d hi=%h lo=%h",
               bus.busy, bus.done, bus.hi, bus.lo);
      run_op(2'd0, 32'd6, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);

      for (int i = 0; i < 24; i++) begin
         run_op(2'($urandom), rnd_opnd(), rnd_opnd(), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), 32'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO register width.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 Port: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Port: a  input  WIDTH  operand rs (register-file rd1); multiplicand/dividend.
REQ-007 Port: b  input  WIDTH  operand rt (register-file rd2); multiplier/divisor.
REQ-008 Port: hi_we  input  1  MTHI write enable.
REQ-009 Port: lo_we  input  1  MTLO write enable.
REQ-010 Port: wd  input  WIDTH  MTHI/MTLO write data.
REQ-011 Port: busy  output  1  operation in progress; the pipeline SHALL stall MFHI/MFLO and new MDU ops while high.
REQ-012 Port: done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-013 Port: hi  output  WIDTH  HI register value.
REQ-014 Port: lo  output  WIDTH  LO register value.

Function
REQ-015 FSM states SHALL be IDLE, CALC and FIX; reset state IDLE.
REQ-016 IDLE: start=1 at an edge SHALL latch op, a and b, convert signed operands to magnitudes, clear the 6-bit iteration counter, and go to CALC.
REQ-017 CALC SHALL perform one radix-2 iteration per cycle (shift-add multiply / restoring divide) for exactly WIDTH cycles, then go to FIX.
REQ-018 FIX SHALL apply the sign correction, write HI/LO, assert done for that cycle, and return to IDLE.
REQ-019 Latency: with start sampled at edge N, HI/LO update at edge N+WIDTH+1; done SHALL be high for the cycle after that edge.
REQ-020 busy SHALL be high in CALC and FIX, and low in IDLE.
REQ-021 MULT/MULTU: {HI,LO} SHALL equal the full 2*WIDTH-bit signed/unsigned product.
REQ-022 DIV/DIVU: LO SHALL equal the quotient truncated toward zero, and HI the remainder with the sign of the dividend.
REQ-023 Divide by zero (b=0): LO SHALL be all-ones and HI SHALL equal a, for both DIV and DIVU.
REQ-024 Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): LO SHALL be 0x80000000 and HI SHALL be 0.
REQ-025 start while busy SHALL be ignored (not queued).
REQ-026 hi_we/lo_we in IDLE SHALL write wd to HI/LO at the edge; while busy they SHALL be ignored.
REQ-027 start together with hi_we/lo_we in IDLE: both SHALL take effect; the MTHI/MTLO value is visible until the result overwrites it.
REQ-028 hi and lo SHALL be driven directly from registers; intermediate CALC values SHALL never appear on them.
REQ-029 Operand inputs SHALL be don't-care after the start edge.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
REQ-031 Reset during CALC/FIX SHALL abort the operation with no HI/LO update; after release the block SHALL accept start normally.

Verification
REQ-032 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after WIDTH+1 edges: hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
REQ-033 MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
REQ-034 DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
REQ-035 DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0; a second start mid-operation -> ignored, single done.
REQ-036 MTLO wd=0x12345678 in IDLE -> lo=0x12345678 next edge; lo_we while busy -> lo unchanged; rst_n low at CALC cycle 10 -> busy=0, hi=lo=0, no done.
